// File: rtl/apb_rr_arbiter_if.sv
// Requester and APB bus signals of the two-port APB round-robin arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_rr_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  resp0_valid;
    logic [DATA_WIDTH-1:0] resp0_rdata;
    logic                  resp0_err;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  resp1_valid;
    logic [DATA_WIDTH-1:0] resp1_rdata;
    logic                  resp1_err;

    logic                  PSEL1;
    logic                  PSEL2;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_rdata, resp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_rdata, resp1_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin APB master front end (IDLE -> SETUP -> ACCESS).
// Define APB_ARB_TIMEOUT_EN to terminate ACCESS with an error after TIMEOUT_CYCLES.
module apb_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic              PCLK,
    input logic              PRESETn,
    apb_rr_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  resp0_valid_q, resp0_valid_d;
    logic [DATA_WIDTH-1:0] resp0_rdata_q, resp0_rdata_d;
    logic                  resp0_err_q, resp0_err_d;
    logic                  resp1_valid_q, resp1_valid_d;
    logic [DATA_WIDTH-1:0] resp1_rdata_q, resp1_rdata_d;
    logic                  resp1_err_q, resp1_err_d;

    logic                  grant_any;
    logic                  grant_id;
    logic                  timeout;
    logic                  done;
    logic                  done_err;
    logic [DATA_WIDTH-1:0] done_rdata;
    logic                  active;

    // On contention the requester that did not win last time is granted.
    assign grant_any = (state_q == ST_IDLE) & (bus.req0_valid | bus.req1_valid);
    assign grant_id  = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] tmo_q, tmo_d;

    assign timeout = (state_q == ST_ACCESS) & ~bus.PREADY &
                     (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_SETUP) begin
            tmo_d = '0;
        end else if ((state_q == ST_ACCESS) && !bus.PREADY && !timeout) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    assign done       = (state_q == ST_ACCESS) & (bus.PREADY | timeout);
    assign done_err   = timeout | bus.PSLVERR;
    assign done_rdata = (timeout | write_q) ? '0 : bus.PRDATA;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp0_valid_d = 1'b0;
        resp0_rdata_d = resp0_rdata_q;
        resp0_err_d   = resp0_err_q;
        resp1_valid_d = 1'b0;
        resp1_rdata_d = resp1_rdata_q;
        resp1_err_d   = resp1_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d      = ST_SETUP;
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    write_d      = grant_id ? bus.req1_write : bus.req0_write;
                    addr_d       = grant_id ? bus.req1_addr  : bus.req0_addr;
                    wdata_d      = grant_id ? bus.req1_wdata : bus.req0_wdata;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (done) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        resp1_valid_d = 1'b1;
                        resp1_rdata_d = done_rdata;
                        resp1_err_d   = done_err;
                    end else begin
                        resp0_valid_d = 1'b1;
                        resp0_rdata_d = done_rdata;
                        resp0_err_d   = done_err;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            resp0_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp0_err_q   <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp1_rdata_q <= '0;
            resp1_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp0_valid_q <= resp0_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp0_err_q   <= resp0_err_d;
            resp1_valid_q <= resp1_valid_d;
            resp1_rdata_q <= resp1_rdata_d;
            resp1_err_q   <= resp1_err_d;
        end
    end

    // Bus outputs decode straight from state so an async reset drops them at once.
    assign active      = (state_q == ST_SETUP) | (state_q == ST_ACCESS);
    assign bus.PSEL1   = active & ~addr_q[ADDR_WIDTH-1];
    assign bus.PSEL2   = active & addr_q[ADDR_WIDTH-1];
    assign bus.PENABLE = (state_q == ST_ACCESS);
    assign bus.PWRITE  = active & write_q;
    assign bus.PADDR   = active ? addr_q : '0;
    assign bus.PWDATA  = (active & write_q) ? wdata_q : '0;

    assign bus.req0_ready  = PRESETn & grant_any & ~grant_id;
    assign bus.req1_ready  = PRESETn & grant_any & grant_id;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp0_rdata = resp0_rdata_q;
    assign bus.resp0_err   = resp0_err_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp1_rdata = resp1_rdata_q;
    assign bus.resp1_err   = resp1_err_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: per-requester response scoreboards,
// a simple APB slave model, and bus invariants checked every cycle.
module tb_apb_rr_arbiter;

    logic PCLK;
    logic PRESETn;

    int checks = 0;
    int errors = 0;

    int         slave_waits = 0;
    logic [7:0] slave_rdata = 8'h00;
    logic       slave_err   = 1'b0;
    int         slv_cnt     = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         grant_log[$];

    apb_rr_arbiter_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus ();

    apb_rr_arbiter #(
        .ADDR_WIDTH    (9),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        check("drain_left", q0.size() + q1.size(), 0);
    endtask

    // APB slave: PREADY after slave_waits wait states of each ACCESS phase.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 8'h00;
        bus.PSLVERR = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            if ((bus.PSEL1 | bus.PSEL2) && bus.PENABLE) begin
                if (slv_cnt >= slave_waits) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = slave_rdata;
                    bus.PSLVERR = slave_err;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 8'hEE;
                    bus.PSLVERR = 1'b0;
                end
                slv_cnt++;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 8'h00;
                bus.PSLVERR = 1'b0;
                slv_cnt     = 0;
            end
        end
    end

    // Response monitor and bus invariants.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge PCLK);
            #1;
            if (PRESETn) begin
                check("psel_exclusive", bus.PSEL1 & bus.PSEL2, 0);
                if (bus.PENABLE) check("penable_one_sel", bus.PSEL1 ^ bus.PSEL2, 1);
                if (bus.resp0_valid) begin
                    if (q0.size() == 0) check("resp0_unexpected", bus.resp0_valid, 0);
                    else begin
                        e = q0.pop_front();
                        check("resp0_rdata", bus.resp0_rdata, e[7:0]);
                        check("resp0_err", bus.resp0_err, e[8]);
                    end
                end
                if (bus.resp1_valid) begin
                    if (q1.size() == 0) check("resp1_unexpected", bus.resp1_valid, 0);
                    else begin
                        e = q1.pop_front();
                        check("resp1_rdata", bus.resp1_rdata, e[7:0]);
                        check("resp1_err", bus.resp1_err, e[8]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acc;
        PRESETn        = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_write = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_wdata = '0;
        bus.req1_valid = 1'b0;
        bus.req1_write = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_wdata = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_psel1", bus.PSEL1, 0);
        check("rst_psel2", bus.PSEL2, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_pwrite", bus.PWRITE, 0);
        check("rst_paddr", bus.PADDR, 0);
        check("rst_pwdata", bus.PWDATA, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_resp0_valid", bus.resp0_valid, 0);
        check("rst_resp1_valid", bus.resp1_valid, 0);
        check("rst_resp0_rdata", bus.resp0_rdata, 0);
        check("rst_resp1_err", bus.resp1_err, 0);
        PRESETn = 1'b1;
        tick();
        tick();
        check("idle_psel1", bus.PSEL1, 0);
        check("idle_penable", bus.PENABLE, 0);

        // req0 write to slave1, zero wait states
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 9'h012;
        bus.req0_wdata = 8'hA5;
        #1;
        check("w_ready0", bus.req0_ready, 1);
        q0.push_back({1'b0, 8'h00});
        tick();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 9'h1FF;
        bus.req0_wdata = 8'h00;
        #1;
        check("w_setup_psel1", bus.PSEL1, 1);
        check("w_setup_psel2", bus.PSEL2, 0);
        check("w_setup_penable", bus.PENABLE, 0);
        tick();
        check("w_acc_penable", bus.PENABLE, 1);
        check("w_acc_pwrite", bus.PWRITE, 1);
        check("w_acc_paddr", bus.PADDR, 9'h012);
        check("w_acc_pwdata", bus.PWDATA, 8'hA5);
        tick();
        check("w_resp0_valid", bus.resp0_valid, 1);
        check("w_resp0_err", bus.resp0_err, 0);

        // req1 read from slave2 with two wait states
        slave_waits    = 2;
        slave_rdata    = 8'h3C;
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b0;
        bus.req1_addr  = 9'h105;
        bus.req1_wdata = 8'h99;
        #1;
        check("r_ready1", bus.req1_ready, 1);
        check("r_ready0", bus.req0_ready, 0);
        q1.push_back({1'b0, 8'h3C});
        tick();
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 9'h0FF;
        #1;
        check("r_setup_psel2", bus.PSEL2, 1);
        check("r_setup_psel1", bus.PSEL1, 0);
        check("r_setup_penable", bus.PENABLE, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_acc_penable", bus.PENABLE, 1);
            check("r_acc_psel2", bus.PSEL2, 1);
            check("r_acc_paddr", bus.PADDR, 9'h105);
            check("r_acc_pwrite", bus.PWRITE, 0);
            check("r_acc_pwdata", bus.PWDATA, 0);
        end
        tick();
        check("r_resp1_valid", bus.resp1_valid, 1);
        check("r_resp1_rdata", bus.resp1_rdata, 8'h3C);
        check("r_resp0_quiet", bus.resp0_valid, 0);

        // both requesters held valid: grants must alternate starting with 0
        slave_waits    = 0;
        slave_rdata    = 8'h5A;
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b0;
        bus.req0_addr  = 9'h020;
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b1;
        bus.req1_addr  = 9'h130;
        bus.req1_wdata = 8'h66;
        #1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            check("dual_both_ready", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready) begin
                grant_log.push_back(1'b0);
                q0.push_back({1'b0, 8'h5A});
                n++;
            end
            if (bus.req1_ready) begin
                grant_log.push_back(1'b1);
                q1.push_back({1'b0, 8'h00});
                n++;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("dual_grant_count", n, 4);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("dual_grant_order", grant_log[i], i % 2);
        end
        drain();

        // read with PSLVERR on the PREADY cycle
        slave_err      = 1'b1;
        slave_rdata    = 8'h77;
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b0;
        bus.req0_addr  = 9'h033;
        #1;
        check("e_ready0", bus.req0_ready, 1);
        q0.push_back({1'b1, 8'h77});
        tick();
        bus.req0_valid = 1'b0;
        drain();
        slave_err = 1'b0;
        tick();
        check("e_err_hold", bus.resp0_err, 1);

        // reset in the middle of a stalled ACCESS abandons the transfer
        slave_waits    = 1000;
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 9'h044;
        bus.req0_wdata = 8'h11;
        #1;
        check("x_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("x_acc_psel1", bus.PSEL1, 1);
        check("x_acc_penable", bus.PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("x_rst_psel1", bus.PSEL1, 0);
        check("x_rst_penable", bus.PENABLE, 0);
        check("x_rst_pwrite", bus.PWRITE, 0);
        tick();
        tick();
        PRESETn     = 1'b1;
        slave_waits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("x_no_resp0", bus.resp0_valid, 0);
        end

`ifdef APB_ARB_TIMEOUT_EN
        // stuck slave: 16 ACCESS cycles, then an error response with zero data
        slave_waits    = 1000;
        slave_rdata    = 8'hC3;
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b0;
        bus.req1_addr  = 9'h1AB;
        #1;
        check("t_ready1", bus.req1_ready, 1);
        q1.push_back({1'b1, 8'h00});
        tick();
        bus.req1_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.PENABLE) break;
            acc++;
        end
        check("t_access_cycles", acc, 16);
        check("t_resp1_valid", bus.resp1_valid, 1);
        check("t_psel2_dropped", bus.PSEL2, 0);
        slave_waits    = 0;
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 9'h010;
        bus.req0_wdata = 8'h42;
        #1;
        check("t_next_ready0", bus.req0_ready, 1);
        q0.push_back({1'b0, 8'h00});
        tick();
        bus.req0_valid = 1'b0;
        drain();
`else
        acc = 0;
`endif

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Two-requester APB master front end that shares the single APB bus (slave1/slave2 split on address MSB) between requester 0 and requester 1.
- Round-robin arbitration, then a full APB SETUP/ACCESS sequence with wait-state support.
- Returns read data and error status to the requester that owns the transfer.
- Sits between on-chip requesters (e.g. CPU port, DMA port) and the slave1/slave2 pair, in place of a single-source bridge.

Parameters:
- ADDR_WIDTH, 9, APB address width; bit ADDR_WIDTH-1 selects the slave (0 = slave1, 1 = slave2).
- DATA_WIDTH, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before a forced error. Used only with APB_ARB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a transfer pending
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_WIDTH  transfer address
- req0_wdata  in  DATA_WIDTH  write data
- req0_ready  out  1  one-cycle accept pulse; the request is latched in this cycle
- resp0_valid  out  1  one-cycle completion pulse
- resp0_rdata  out  DATA_WIDTH  read data; 0 for writes
- resp0_err  out  1  PSLVERR (or timeout) of the completed transfer
- req1_*/resp1_*  same set for requester 1
- PSEL1  out  1  slave1 select
- PSEL2  out  1  slave2 select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  muxed slave read data
- PREADY  in  1  muxed slave ready
- PSLVERR  in  1  muxed slave error

Behaviour:
- Reset (asynchronous, PRESETn=0):
  - State = IDLE.
  - All outputs = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - A reset mid-transfer abandons the transfer: no resp pulse, PSELx/PENABLE drop immediately.
- State machine: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any reqN_valid=1, grant one requester:
    - only one valid: that one;
    - both valid: the one not equal to last_grant.
  - reqN_ready=1 for the granted requester for exactly this cycle.
  - Latch write, addr, wdata and owner; last_grant <= owner; next state SETUP.
  - No valid: stay in IDLE; all APB outputs 0.
- SETUP (exactly 1 cycle):
  - PSEL1 = ~addr[MSB], PSEL2 = addr[MSB], PENABLE = 0.
  - PWRITE/PADDR/PWDATA driven from the latched request; PWDATA = 0 on reads.
  - Next state ACCESS.
- ACCESS:
  - Same selects and bus values as SETUP, plus PENABLE = 1.
  - PREADY=0: stay in ACCESS (wait state); all APB outputs held stable.
  - PREADY=1: sample PRDATA (reads only) and PSLVERR; next state IDLE.
- Response:
  - respN_valid pulses for 1 cycle for the owner, in the cycle after PREADY is sampled high (the first IDLE cycle).
  - respN_rdata/respN_err are valid with that pulse and hold until the next completion for that requester.
- Latency, zero wait states:
  - accept (cycle 0), SETUP (1), ACCESS (2), resp (3).
  - A new grant may occur in the same cycle as a resp pulse, so throughput is 1 transfer per 3 cycles.
- Fairness:
  - Under continuous dual requests, grants strictly alternate 0,1,0,1.
  - A lone requester may win consecutively.
- Request-side rules:
  - reqN_* must stay stable while valid and not ready.
  - After acceptance, changes to reqN_* do not affect the active transfer.
- PSEL1 and PSEL2 are never both 1. PENABLE=1 only when exactly one PSEL is 1.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES-1 with PREADY still 0, the transfer terminates: next state IDLE, resp pulse with err=1 and rdata=0.
  - PSEL/PENABLE drop in the IDLE cycle.
- Not defined: ACCESS waits indefinitely for PREADY; no counter logic is present.

Test Plan:
- Reset then idle: all outputs 0; hold PRESETn=0 mid-ACCESS -> PSEL1/PENABLE drop asynchronously, no resp0_valid afterwards.
- req0 write addr=0x012, data=0xA5, PREADY=1 -> cycle 1: PSEL1=1, PENABLE=0; cycle 2: PENABLE=1, PWRITE=1, PADDR=0x012, PWDATA=0xA5; cycle 3: resp0_valid=1, resp0_err=0.
- req1 read addr=0x105, slave2 inserts 2 wait states, PRDATA=0x3C -> PSEL2=1, ACCESS lasts 3 cycles with bus stable, then resp1_valid=1, resp1_rdata=0x3C.
- req0 and req1 held valid for 4 transfers -> grant order 0,1,0,1; each resp goes only to its owner.
- Read with PSLVERR=1 on the PREADY cycle -> respN_err=1.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck 0 -> 16 ACCESS cycles, then resp err=1, rdata=0, and the next grant proceeds normally.
